shot_controller: RTL and testbench

Frame-rate motion and scoring controller for the shot simulator. It accepts a shoot command with launch velocities, integrates a gravity trajectory once per video frame, and drives the `ball_x`/`ball_y` coordinates consumed by `pixel_Gen`. It detects a made basket or a miss, keeps a saturating score, and returns the ball to the start position after a hold period. It sits between the debounced user inputs / VGA sync block and the pixel generator.

---
 rtl/shot_pkg.sv | 30 +++
 rtl/shot_controller_trajectory_step.sv | 69 ++++++
 rtl/shot_controller.sv | 171 +++++++++++++++++
 tb/tb_shot_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
// Shared definitions for the shot simulator: FSM encodings, default court geometry
// (must agree with the hoop drawing in basketballHoop) and score saturation.
package shot_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLIGHT = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    localparam int DEF_START_X     = 80;
    localparam int DEF_START_Y     = 400;
    localparam int DEF_FLOOR_Y     = 440;
    localparam int DEF_X_MAX       = 630;
    localparam int DEF_RIM_XL      = 520;
    localparam int DEF_RIM_XR      = 560;
    localparam int DEF_RIM_Y       = 200;
    localparam int DEF_GRAV        = 1;
    localparam int DEF_VY_MAX      = 31;
    localparam int DEF_HOLD_FRAMES = 60;

    localparam logic [6:0] SCORE_MAX = 7'd99;

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        if (v >= SCORE_MAX) begin
            return SCORE_MAX;
        end else begin
            return v + 7'd1;
        end
    endfunction

endpackage

// File: rtl/shot_controller_trajectory_step.sv
// One frame of ballistic integration: next position, next vertical speed and the
// basket / floor / side-wall outcome flags evaluated from the pre-update state.
module trajectory_step
    import shot_pkg::*;
#(
    parameter int RIM_XL  = DEF_RIM_XL,
    parameter int RIM_XR  = DEF_RIM_XR,
    parameter int RIM_Y   = DEF_RIM_Y,
    parameter int FLOOR_Y = DEF_FLOOR_Y,
    parameter int X_MAX   = DEF_X_MAX,
    parameter int GRAV    = DEF_GRAV,
    parameter int VY_MAX  = DEF_VY_MAX
) (
    input  logic        [9:0] x,
    input  logic        [9:0] y,
    input  logic        [3:0] vx,
    input  logic signed [7:0] vy,
    output logic        [9:0] nx,
    output logic        [9:0] ny,
    output logic signed [7:0] vy_next,
    output logic              hit,
    output logic              floor_hit,
    output logic              side_hit
);

    localparam logic        [9:0] RIM_XL_V  = 10'(RIM_XL);
    localparam logic        [9:0] RIM_XR_V  = 10'(RIM_XR);
    localparam logic        [9:0] RIM_Y_V   = 10'(RIM_Y);
    localparam logic        [9:0] FLOOR_Y_V = 10'(FLOOR_Y);
    localparam logic        [9:0] X_MAX_V   = 10'(X_MAX);
    localparam logic signed [8:0] GRAV_V    = 9'(GRAV);
    localparam logic signed [8:0] VY_MAX_V  = 9'(VY_MAX);

    logic signed [10:0] y_ext_s;
    logic signed [10:0] vy_ext_s;
    logic signed [10:0] ny_sum_s;
    logic signed [8:0]  vy_sum_s;

    assign y_ext_s  = {1'b0, y};
    assign vy_ext_s = {{3{vy[7]}}, vy};
    assign ny_sum_s = y_ext_s + vy_ext_s;
    assign vy_sum_s = {vy[7], vy} + GRAV_V;

    // Position update; a ball flying above the top edge is pinned at row 0.
    always_comb begin
        nx = x + {6'd0, vx};
        if (ny_sum_s[10]) begin
            ny = 10'd0;
        end else begin
            ny = ny_sum_s[9:0];
        end
    end

    // Gravity with a terminal downward speed.
    always_comb begin
        if (vy_sum_s > VY_MAX_V) begin
            vy_next = VY_MAX_V[7:0];
        end else begin
            vy_next = vy_sum_s[7:0];
        end
    end

    // A basket needs a downward crossing of the rim plane inside the window.
    assign hit       = (vy > 8'sd0) && (y < RIM_Y_V) && (ny >= RIM_Y_V) &&
                       (nx >= RIM_XL_V) && (nx <= RIM_XR_V);
    assign floor_hit = (ny >= FLOOR_Y_V);
    assign side_hit  = (nx >= X_MAX_V);

endmodule

// File: rtl/shot_controller.sv
// Frame-rate shot FSM: launches on a shoot edge, integrates the trajectory per
// frame, scores or misses, holds the result, then returns the ball to start.
module shot_controller
    import shot_pkg::*;
#(
    parameter int START_X     = DEF_START_X,
    parameter int START_Y     = DEF_START_Y,
    parameter int FLOOR_Y     = DEF_FLOOR_Y,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int RIM_XL      = DEF_RIM_XL,
    parameter int RIM_XR      = DEF_RIM_XR,
    parameter int RIM_Y       = DEF_RIM_Y,
    parameter int GRAV        = DEF_GRAV,
    parameter int VY_MAX      = DEF_VY_MAX,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       shoot,
    input  logic [3:0] launch_vx,
    input  logic [4:0] launch_vy,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       in_flight,
    output logic       score_pulse,
    output logic       miss_pulse,
    output logic [6:0] score
);

    localparam int HOLD_W = ($clog2(HOLD_FRAMES + 1) > 6) ? $clog2(HOLD_FRAMES + 1) : 6;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [9:0] START_X_V = 10'(START_X);
    localparam logic [9:0] START_Y_V = 10'(START_Y);
    localparam logic [9:0] FLOOR_Y_V = 10'(FLOOR_Y);
    localparam logic [9:0] X_MAX_V   = 10'(X_MAX);

    logic [1:0]        state_r;
    logic              shoot_r;
    logic              rise_r;
    logic [3:0]        vx_r;
    logic signed [7:0] vy_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [9:0]        ball_x_r;
    logic [9:0]        ball_y_r;
    logic              in_flight_r;
    logic              score_pulse_r;
    logic              miss_pulse_r;
    logic [6:0]        score_r;

    logic [9:0]        nx_s;
    logic [9:0]        ny_s;
    logic signed [7:0] vy_next_s;
    logic              hit_s;
    logic              floor_s;
    logic              side_s;

    trajectory_step #(
        .RIM_XL (RIM_XL),
        .RIM_XR (RIM_XR),
        .RIM_Y  (RIM_Y),
        .FLOOR_Y(FLOOR_Y),
        .X_MAX  (X_MAX),
        .GRAV   (GRAV),
        .VY_MAX (VY_MAX)
    ) u_step (
        .x        (ball_x_r),
        .y        (ball_y_r),
        .vx       (vx_r),
        .vy       (vy_r),
        .nx       (nx_s),
        .ny       (ny_s),
        .vy_next  (vy_next_s),
        .hit      (hit_s),
        .floor_hit(floor_s),
        .side_hit (side_s)
    );

    // Registered rising-edge detect on the debounced shoot level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shoot_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            shoot_r <= shoot;
            rise_r  <= shoot & ~shoot_r;
        end
    end

    // Shot FSM with motion, scoring and hold counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            vx_r          <= 4'd0;
            vy_r          <= 8'sd0;
            hold_cnt_r    <= '0;
            ball_x_r      <= START_X_V;
            ball_y_r      <= START_Y_V;
            in_flight_r   <= 1'b0;
            score_pulse_r <= 1'b0;
            miss_pulse_r  <= 1'b0;
            score_r       <= 7'd0;
        end else begin
            score_pulse_r <= 1'b0;
            miss_pulse_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ball_x_r   <= START_X_V;
                    ball_y_r   <= START_Y_V;
                    hold_cnt_r <= '0;
                    if (rise_r) begin
                        vx_r        <= launch_vx;
                        vy_r        <= 8'sd0 - $signed({3'b000, launch_vy});
                        state_r     <= ST_FLIGHT;
                        in_flight_r <= 1'b1;
                    end else begin
                        in_flight_r <= 1'b0;
                    end
                end
                ST_FLIGHT: begin
                    if (frame_tick) begin
                        vy_r     <= vy_next_s;
                        ball_x_r <= side_s  ? X_MAX_V   : nx_s;
                        ball_y_r <= floor_s ? FLOOR_Y_V : ny_s;
                        if (hit_s) begin
                            score_r       <= sat_inc(score_r);
                            score_pulse_r <= 1'b1;
                            state_r       <= ST_RESULT;
                            in_flight_r   <= 1'b0;
                        end else if (floor_s || side_s) begin
                            miss_pulse_r <= 1'b1;
                            state_r      <= ST_RESULT;
                            in_flight_r  <= 1'b0;
                        end else begin
                            in_flight_r <= 1'b1;
                        end
                    end else begin
                        in_flight_r <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (frame_tick) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            state_r    <= ST_IDLE;
                            hold_cnt_r <= '0;
                            ball_x_r   <= START_X_V;
                            ball_y_r   <= START_Y_V;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_flight_r <= 1'b0;
                end
            endcase
        end
    end

    assign ball_x      = ball_x_r;
    assign ball_y      = ball_y_r;
    assign in_flight   = in_flight_r;
    assign score_pulse = score_pulse_r;
    assign miss_pulse  = miss_pulse_r;
    assign score       = score_r;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench: three instances share stimulus (default geometry, a low rim over
// the start column, and a near side wall); each scenario checks its instance.
module tb_shot_controller;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       shoot;
    logic [3:0] launch_vx;
    logic [4:0] launch_vy;

    logic [9:0] d_x, d_y, s_x, s_y, w_x, w_y;
    logic       d_fl, d_sp, d_mp, s_fl, s_sp, s_mp, w_fl, w_sp, w_mp;
    logic [6:0] d_sc, s_sc, w_sc;

    int n_cmp = 0;
    int n_err = 0;

    shot_controller u_dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .shoot(shoot),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .ball_x(d_x), .ball_y(d_y), .in_flight(d_fl),
        .score_pulse(d_sp), .miss_pulse(d_mp), .score(d_sc)
    );

    shot_controller #(.RIM_XL(80), .RIM_XR(100), .RIM_Y(390)) u_score (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .shoot(shoot),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .ball_x(s_x), .ball_y(s_y), .in_flight(s_fl),
        .score_pulse(s_sp), .miss_pulse(s_mp), .score(s_sc)
    );

    shot_controller #(.X_MAX(200)) u_side (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .shoot(shoot),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .ball_x(w_x), .ball_y(w_y), .in_flight(w_fl),
        .score_pulse(w_sp), .miss_pulse(w_mp), .score(w_sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic launch(input logic [3:0] vx, input logic [4:0] vy);
        @(negedge clk);
        launch_vx = vx;
        launch_vy = vy;
        shoot     = 1'b1;
        repeat (2) @(negedge clk);
        shoot = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) tick();
        n_cmp++; if (d_x !== 10'd80) begin n_err++; $display("FAIL reset_x: got %0d expected 80", d_x); end
        n_cmp++; if (d_y !== 10'd400) begin n_err++; $display("FAIL reset_y: got %0d expected 400", d_y); end
        n_cmp++; if (d_fl !== 1'b0) begin n_err++; $display("FAIL reset_in_flight: got %b expected 0", d_fl); end
        n_cmp++; if (d_sc !== 7'd0) begin n_err++; $display("FAIL reset_score: got %0d expected 0", d_sc); end
        n_cmp++; if ({d_sp, d_mp} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b expected 00", {d_sp, d_mp}); end
    endtask

    task automatic test_launch_with_tick();
        do_reset();
        @(negedge clk);
        launch_vx  = 4'd3;
        launch_vy  = 5'd0;
        shoot      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        shoot = 1'b0;
        n_cmp++; if (d_fl !== 1'b1) begin n_err++; $display("FAIL launch_in_flight: got %b expected 1", d_fl); end
        n_cmp++; if (d_x !== 10'd80 || d_y !== 10'd400) begin n_err++; $display("FAIL launch_no_motion: got (%0d,%0d) expected (80,400)", d_x, d_y); end
        launch_vx = 4'd9;
        tick();
        n_cmp++; if (d_x !== 10'd83) begin n_err++; $display("FAIL launch_vx_latched: got %0d expected 83", d_x); end
    endtask

    task automatic test_vertical_drop();
        int exp_y;
        do_reset();
        launch(4'd0, 5'd0);
        n_cmp++; if (d_fl !== 1'b1) begin n_err++; $display("FAIL drop_in_flight: got %b expected 1", d_fl); end
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_y = 400 + ((k - 1) * k) / 2;
            n_cmp++; if (d_y !== 10'(exp_y) || d_mp !== 1'b0) begin n_err++; $display("FAIL drop_y tick %0d: got y=%0d miss=%b expected y=%0d miss=0", k, d_y, d_mp, exp_y); end
        end
        tick();
        n_cmp++; if (d_y !== 10'd440) begin n_err++; $display("FAIL drop_floor_y: got %0d expected 440", d_y); end
        n_cmp++; if (d_mp !== 1'b1 || d_fl !== 1'b0) begin n_err++; $display("FAIL drop_miss: got miss=%b fl=%b expected miss=1 fl=0", d_mp, d_fl); end
        @(negedge clk);
        n_cmp++; if (d_mp !== 1'b0) begin n_err++; $display("FAIL drop_miss_once: got %b expected 0", d_mp); end
        repeat (59) tick();
        n_cmp++; if (d_y !== 10'd440) begin n_err++; $display("FAIL drop_hold_59: got y=%0d expected 440", d_y); end
        tick();
        n_cmp++; if (d_x !== 10'd80 || d_y !== 10'd400) begin n_err++; $display("FAIL drop_return: got (%0d,%0d) expected (80,400)", d_x, d_y); end
    endtask

    task automatic test_apex();
        int exp_y [7] = '{395, 391, 388, 386, 385, 385, 386};
        do_reset();
        launch(4'd0, 5'd5);
        for (int k = 0; k < 7; k++) begin
            tick();
            n_cmp++; if (d_y !== 10'(exp_y[k]) || d_x !== 10'd80) begin n_err++; $display("FAIL apex tick %0d: got (%0d,%0d) expected (80,%0d)", k + 1, d_x, d_y, exp_y[k]); end
        end
    endtask

    task automatic test_score();
        do_reset();
        launch(4'd0, 5'd5);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 3) begin
                n_cmp++; if (s_y !== 10'd388 || s_sp !== 1'b0) begin n_err++; $display("FAIL score_upward: got y=%0d sp=%b expected y=388 sp=0", s_y, s_sp); end
            end
            if (k == 8) begin
                n_cmp++; if (s_sc !== 7'd0 || s_fl !== 1'b1) begin n_err++; $display("FAIL score_before: got sc=%0d fl=%b expected sc=0 fl=1", s_sc, s_fl); end
            end
        end
        n_cmp++; if (s_sp !== 1'b1 || s_sc !== 7'd1) begin n_err++; $display("FAIL score_hit: got sp=%b sc=%0d expected sp=1 sc=1", s_sp, s_sc); end
        n_cmp++; if (s_y !== 10'd391 || s_fl !== 1'b0) begin n_err++; $display("FAIL score_pos: got y=%0d fl=%b expected y=391 fl=0", s_y, s_fl); end
        @(negedge clk);
        n_cmp++; if (s_sp !== 1'b0) begin n_err++; $display("FAIL score_pulse_once: got %b expected 0", s_sp); end
    endtask

    task automatic test_side_miss();
        do_reset();
        launch(4'd15, 5'd20);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) begin
                @(negedge clk) shoot = 1'b1;
                repeat (3) @(negedge clk);
                shoot = 1'b0;
                repeat (2) @(negedge clk);
                n_cmp++; if (w_fl !== 1'b1 || w_x !== 10'd125) begin n_err++; $display("FAIL side_shoot_ignored: got fl=%b x=%0d expected fl=1 x=125", w_fl, w_x); end
            end
            if (k < 8) begin
                n_cmp++; if (w_x !== 10'(80 + 15 * k) || w_mp !== 1'b0) begin n_err++; $display("FAIL side_x tick %0d: got x=%0d miss=%b expected x=%0d miss=0", k, w_x, w_mp, 80 + 15 * k); end
            end
        end
        n_cmp++; if (w_x !== 10'd200 || w_y !== 10'd268) begin n_err++; $display("FAIL side_pos: got (%0d,%0d) expected (200,268)", w_x, w_y); end
        n_cmp++; if (w_mp !== 1'b1 || w_fl !== 1'b0 || w_sp !== 1'b0) begin n_err++; $display("FAIL side_miss: got miss=%b fl=%b sp=%b expected 1 0 0", w_mp, w_fl, w_sp); end
        repeat (5) tick();
        @(negedge clk) shoot = 1'b1;
        repeat (3) @(negedge clk);
        shoot = 1'b0;
        repeat (55) tick();
        repeat (5) @(negedge clk);
        n_cmp++; if (w_fl !== 1'b0 || w_x !== 10'd80) begin n_err++; $display("FAIL side_no_queue: got fl=%b x=%0d expected fl=0 x=80", w_fl, w_x); end
    endtask

    task automatic test_saturation_and_async_reset();
        do_reset();
        for (int n = 1; n <= 100; n++) begin
            launch(4'd0, 5'd5);
            repeat (9) tick();
            if (n == 99) begin
                n_cmp++; if (s_sc !== 7'd99) begin n_err++; $display("FAIL sat_99: got %0d expected 99", s_sc); end
            end
            repeat (60) tick();
        end
        n_cmp++; if (s_sc !== 7'd99) begin n_err++; $display("FAIL sat_hold: got %0d expected 99", s_sc); end
        launch(4'd0, 5'd5);
        repeat (2) tick();
        n_cmp++; if (s_fl !== 1'b1 || s_y !== 10'd391) begin n_err++; $display("FAIL mid_flight: got fl=%b y=%0d expected fl=1 y=391", s_fl, s_y); end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (s_x !== 10'd80 || s_y !== 10'd400 || s_fl !== 1'b0) begin n_err++; $display("FAIL async_reset_pos: got (%0d,%0d) fl=%b expected (80,400) 0", s_x, s_y, s_fl); end
        n_cmp++; if (s_sc !== 7'd0 || s_sp !== 1'b0 || s_mp !== 1'b0) begin n_err++; $display("FAIL async_reset_score: got sc=%0d sp=%b mp=%b expected 0 0 0", s_sc, s_sp, s_mp); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        shoot      = 1'b0;
        launch_vx  = 4'd0;
        launch_vy  = 5'd0;
        test_reset();
        test_launch_with_tick();
        test_vertical_drop();
        test_apex();
        test_score();
        test_side_miss();
        test_saturation_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
